// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM states, default width and
// the counter width helper.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One extra bit keeps the counter from wrapping at WIDTH-1 for powers of two.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-adder stages; the two stage carries
// can never both be set, so a plain OR combines them.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha1_s;
    logic ha1_c;
    logic ha2_c;

    assign ha1_s = x ^ y;
    assign ha1_c = x & y;
    assign s     = ha1_s ^ ci;
    assign ha2_c = ha1_s & ci;
    assign co    = ha1_c | ha2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts one operand bundle, adds one bit per cycle through a
// single full-adder cell, then presents the registered sum until consumed.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = count_width(WIDTH);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic             cout_reg;
    logic [CW-1:0]    count;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;

    assign last_bit = (count == CW'(WIDTH - 1));

    fa_cell u_fa (
        .x  (a_reg[0]),
        .y  (b_reg[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    sum_reg <= {fa_s, sum_reg[WIDTH-1:1]};
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    carry   <= fa_co;
                    count   <= count + CW'(1);
                    if (last_bit) begin
                        cout_reg <= fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus randomized
// operands checked against a plain-arithmetic reference sum.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int check_count;
    int pass_count;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        check_count++;
        if (got === want) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Waits for in_ready and presents one operand bundle; returns just after the accepting edge.
    task automatic startOp(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci, output bit ok);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        ok = in_ready;
        if (!ok) begin
            checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        a        = aa;
        b        = bb;
        cin      = ci;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci,
                                 input int hold_cycles, input bit noise);
        bit               ok;
        int               edges;
        logic [W:0]       expected;
        expected = (W+1)'(aa) + (W+1)'(bb) + (W+1)'(ci);
        out_ready = 1'b0;
        startOp(aa, bb, ci, ok);
        if (!ok) return;
        edges = 1;
        checkOutput("in_ready_busy", 64'(in_ready), 64'd0);
        if (noise) begin
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            in_valid = 1'b1;
        end
        while (!out_valid && edges < W + 10) begin
            step();
            edges++;
        end
        in_valid = 1'b0;
        checkOutput("latency_edges", 64'(edges), 64'(W + 1));
        if (!out_valid) return;
        checkOutput("sum", 64'(sum), 64'(expected[W-1:0]));
        checkOutput("cout", 64'(cout), 64'(expected[W]));
        for (int i = 0; i < hold_cycles; i++) begin
            step();
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_sum", 64'(sum), 64'(expected[W-1:0]));
            checkOutput("hold_cout", 64'(cout), 64'(expected[W]));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("drain_valid", 64'(out_valid), 64'd0);
        checkOutput("drain_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_sum"}, 64'(sum), 64'd0);
        checkOutput({tag, "_cout"}, 64'(cout), 64'd0);
    endtask

    task automatic checkNoStaleValid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        checkOutput(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        bit ok;
        int guard;
        check_count = 0;
        pass_count  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        step();
        step();
        rst = 1'b0;
        checkResetState("reset");

        $display("[TB] directed cases");
        applyStimulus(8'h0F, 8'h01, 1'b0, 0, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        applyStimulus(8'h50, 8'h0A, 1'b0, 5, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0, 1, 1'b0);
        applyStimulus(8'h12, 8'h34, 1'b1, 0, 1'b1);

        $display("[TB] reset during SHIFT");
        startOp(8'h55, 8'h66, 1'b0, ok);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkResetState("mid_shift_reset");
        checkNoStaleValid("mid_shift_stale_valid");
        applyStimulus(8'h03, 8'h04, 1'b0, 0, 1'b0);

        $display("[TB] reset in DONE");
        startOp(8'hA5, 8'h3C, 1'b1, ok);
        guard = 0;
        while (!out_valid && guard < W + 10) begin
            step();
            guard++;
        end
        checkOutput("done_reached", 64'(out_valid), 64'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkResetState("done_reset");
        checkNoStaleValid("done_stale_valid");

        $display("[TB] randomized cases");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
